spi_burst_sequencer: RTL and testbench

//  Command sequencer upstream of the SPI master IP register interface (I_TX_EN/I_WADDR/I_WDATA/
//  I_RX_EN/I_RADDR/O_RDATA). A start pulse triggers configuration, a BURST_LEN-byte incrementing

---
 rtl/spi_regif_pkg.sv | 36 +++
 rtl/spi_reg_access.sv | 77 +++++++
 rtl/spi_burst_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_spi_burst_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regif_pkg.sv
// Register map, status bit positions and state encodings shared by the SPI burst sequencer and
// its register access helper.
package spi_regif_pkg;

    localparam logic [2:0] AddrRxData  = 3'd0;
    localparam logic [2:0] AddrTxData  = 3'd1;
    localparam logic [2:0] AddrStatus  = 3'd2;
    localparam logic [2:0] AddrControl = 3'd3;
    localparam logic [2:0] AddrSsMask  = 3'd4;

    localparam int unsigned StatRoe  = 3;
    localparam int unsigned StatTrdy = 5;
    localparam int unsigned StatRrdy = 6;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StCfgMask = 4'd1,
        StCfgCtrl = 4'd2,
        StPollT   = 4'd3,
        StWaitT   = 4'd4,
        StWrTx    = 4'd5,
        StPollR   = 4'd6,
        StWaitR   = 4'd7,
        StRdRx    = 4'd8,
        StWaitRx  = 4'd9,
        StCheck   = 4'd10,
        StEnd     = 4'd11,
        StDone    = 4'd12
    } seq_state_e;

    typedef enum logic [0:0] {
        AccIdle = 1'b0,
        AccWait = 1'b1
    } acc_state_e;

endpackage

// File: rtl/spi_reg_access.sv
// Issues a single register write or read to the SPI master IP per request; reads are acknowledged
// with the returned data once the IP read latency has elapsed.
module spi_reg_access
    import spi_regif_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  tx_en_o,
    output logic [2:0]            waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  rx_en_o,
    output logic [2:0]            raddr_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    acc_state_e state_q, state_d;
    logic [1:0] lat_q, lat_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= AccIdle;
            lat_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Requests are only accepted in AccIdle; the sequencer never overlaps them.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        tx_en_o = 1'b0;
        waddr_o = 3'd0;
        wdata_o = '0;
        rx_en_o = 1'b0;
        raddr_o = 3'd0;
        ack_o   = 1'b0;
        rdata_o = '0;
        case (state_q)
            AccIdle: begin
                if (req_i) begin
                    if (we_i) begin
                        tx_en_o = 1'b1;
                        waddr_o = addr_i;
                        wdata_o = wdata_i;
                    end else begin
                        rx_en_o = 1'b1;
                        raddr_o = addr_i;
                        lat_d   = 2'd1;
                        state_d = AccWait;
                    end
                end
            end
            AccWait: begin
                if (lat_q == 2'(RD_LAT)) begin
                    ack_o   = 1'b1;
                    rdata_o = rdata_i;
                    state_d = AccIdle;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            default: state_d = AccIdle;
        endcase
    end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Drives one configure / transmit / loopback-compare burst through the SPI master IP register
// interface per accepted start pulse and reports pass/error status.
module spi_burst_sequencer
    import spi_regif_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 8,
    parameter logic [7:0]  CTRL_WORD  = 8'h00,
    parameter logic [7:0]  SS_SEL     = 8'h01,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic                  I_START,
    input  logic [7:0]            I_SEED,
    output logic                  O_TX_EN,
    output logic [2:0]            O_WADDR,
    output logic [DATA_WIDTH-1:0] O_WDATA,
    output logic                  O_RX_EN,
    output logic [2:0]            O_RADDR,
    input  logic [DATA_WIDTH-1:0] I_RDATA,
    output logic                  O_BUSY,
    output logic                  O_DONE,
    output logic                  O_PASS,
    output logic                  O_ERR,
    output logic [7:0]            O_ERR_CNT,
    output logic [DATA_WIDTH-1:0] O_LAST_RX
);

    localparam int unsigned TmoWidth = $clog2(TIMEOUT + 1);
    localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TIMEOUT - 1);
    localparam logic [7:0] IdxLast = 8'(BURST_LEN - 1);

    seq_state_e state_q, state_d;
    logic [7:0] seed_q, seed_d, idx_q, idx_d, err_cnt_q, err_cnt_d;
    logic [DATA_WIDTH-1:0] last_rx_q, last_rx_d;
    logic pass_q, pass_d, err_q, err_d, tmo_hit_q, tmo_hit_d;
    logic [TmoWidth-1:0] tmo_q, tmo_d;

    logic                  req, we, ack;
    logic [2:0]            addr;
    logic [DATA_WIDTH-1:0] wdata, ack_rdata;
    logic [7:0]            exp_byte;
    logic                  fail_now;

    assign exp_byte = seed_q + idx_q;
    assign fail_now = (err_cnt_q != 8'd0) | tmo_hit_q;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q   <= StIdle;
            seed_q    <= 8'd0;
            idx_q     <= 8'd0;
            err_cnt_q <= 8'd0;
            last_rx_q <= '0;
            pass_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_hit_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
            last_rx_q <= last_rx_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            tmo_hit_q <= tmo_hit_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        last_rx_d = last_rx_q;
        pass_d    = pass_q;
        err_d     = err_q;
        tmo_hit_d = tmo_hit_q;
        tmo_d     = tmo_q;
        req       = 1'b0;
        we        = 1'b0;
        addr      = 3'd0;
        wdata     = '0;
        case (state_q)
            StIdle: begin
                if (I_START) begin
                    pass_d    = 1'b0;
                    err_d     = 1'b0;
                    err_cnt_d = 8'd0;
                    tmo_hit_d = 1'b0;
                    seed_d    = I_SEED;
                    idx_d     = 8'd0;
                    state_d   = StCfgMask;
                end
            end
            StCfgMask: begin
                {req, we, addr, wdata} = {2'b11, AddrSsMask, DATA_WIDTH'(SS_SEL)};
                state_d = StCfgCtrl;
            end
            StCfgCtrl: begin
                {req, we, addr, wdata} = {2'b11, AddrControl, DATA_WIDTH'(CTRL_WORD)};
                tmo_d   = '0;
                state_d = StPollT;
            end
            StPollT, StPollR: begin
                req     = 1'b1;
                addr    = AddrStatus;
                tmo_d   = tmo_q + 1'b1;
                state_d = (state_q == StPollT) ? StWaitT : StWaitR;
            end
            // Abort only on a not-ready ack so no read is left in flight.
            StWaitT, StWaitR: begin
                tmo_d = tmo_q + 1'b1;
                if (ack) begin
                    if (state_q == StWaitT && ack_rdata[StatTrdy]) begin
                        state_d = StWrTx;
                    end else if (state_q == StWaitR && ack_rdata[StatRrdy]) begin
                        state_d = StRdRx;
                    end else if (tmo_q >= TmoLast) begin
                        tmo_hit_d = 1'b1;
                        state_d   = StEnd;
                    end else begin
                        state_d = (state_q == StWaitT) ? StPollT : StPollR;
                    end
                end
            end
            StWrTx: begin
                {req, we, addr, wdata} = {2'b11, AddrTxData, DATA_WIDTH'(exp_byte)};
                tmo_d   = '0;
                state_d = StPollR;
            end
            StRdRx: begin
                req     = 1'b1;
                addr    = AddrRxData;
                state_d = StWaitRx;
            end
            StWaitRx: begin
                if (ack) begin
                    last_rx_d = ack_rdata;
                    state_d   = StCheck;
                end
            end
            StCheck: begin
                if (last_rx_q != DATA_WIDTH'(exp_byte) && err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                if (idx_q == IdxLast) begin
                    state_d = StEnd;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    tmo_d   = '0;
                    state_d = StPollT;
                end
            end
            // Flags settle here so they are already valid during the DONE pulse.
            StEnd: begin
                {req, we, addr, wdata} = {2'b11, AddrSsMask, {DATA_WIDTH{1'b0}}};
                err_d   = fail_now;
                pass_d  = ~fail_now;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    spi_reg_access #(
        .DATA_WIDTH(DATA_WIDTH),
        .RD_LAT    (RD_LAT)
    ) u_access (
        .clk_i  (I_CLK),
        .rst_i  (I_RST),
        .req_i  (req),
        .we_i   (we),
        .addr_i (addr),
        .wdata_i(wdata),
        .tx_en_o(O_TX_EN),
        .waddr_o(O_WADDR),
        .wdata_o(O_WDATA),
        .rx_en_o(O_RX_EN),
        .raddr_o(O_RADDR),
        .rdata_i(I_RDATA),
        .ack_o  (ack),
        .rdata_o(ack_rdata)
    );

    assign O_BUSY    = (state_q != StIdle);
    assign O_DONE    = (state_q == StDone);
    assign O_PASS    = pass_q;
    assign O_ERR     = err_q;
    assign O_ERR_CNT = err_cnt_q;
    assign O_LAST_RX = last_rx_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer: behavioural SPI master IP model with poll delay, loopback
// corruption and a stuck TRDY option, plus a strobe protocol monitor.
module tb_spi_burst_sequencer;

    localparam int unsigned BL  = 8;
    localparam int unsigned TMO = 64;
    localparam int unsigned RDL = 1;

    logic       clk = 1'b0;
    logic       I_RST, I_START;
    logic [7:0] I_SEED;
    logic       O_TX_EN, O_RX_EN, O_BUSY, O_DONE, O_PASS, O_ERR;
    logic [2:0] O_WADDR, O_RADDR;
    logic [7:0] O_WDATA, O_LAST_RX, O_ERR_CNT;
    logic [7:0] I_RDATA = 8'h00;
    logic [35:0] outs;

    int errors = 0;
    int checks = 0;

    // IP model controls and logs
    int         poll_delay   = 0;
    logic [7:0] corrupt_mask = 8'h00;
    bit         trdy_stuck   = 1'b0;
    logic [7:0] tx_log[$];
    int         wr_cnt = 0, ss_wr_cnt = 0, ss_zero_cnt = 0, delay_cnt = 0;
    logic [3:0] byte_idx = 4'd0;
    bit         rx_valid = 1'b0;
    logic [7:0] rx_byte  = 8'h00;

    // Protocol monitor state
    int         done_cnt = 0, proto_viol = 0;
    logic       prev_tx = 1'b0, prev_rx = 1'b0, prev_done = 1'b0;
    logic [2:0] prev_waddr = 3'd0;

    always #5 clk = ~clk;

    spi_burst_sequencer #(
        .DATA_WIDTH(8),
        .BURST_LEN (BL),
        .CTRL_WORD (8'h00),
        .SS_SEL    (8'h01),
        .TIMEOUT   (TMO),
        .RD_LAT    (RDL)
    ) dut (
        .I_CLK    (clk),
        .I_RST    (I_RST),
        .I_START  (I_START),
        .I_SEED   (I_SEED),
        .O_TX_EN  (O_TX_EN),
        .O_WADDR  (O_WADDR),
        .O_WDATA  (O_WDATA),
        .O_RX_EN  (O_RX_EN),
        .O_RADDR  (O_RADDR),
        .I_RDATA  (I_RDATA),
        .O_BUSY   (O_BUSY),
        .O_DONE   (O_DONE),
        .O_PASS   (O_PASS),
        .O_ERR    (O_ERR),
        .O_ERR_CNT(O_ERR_CNT),
        .O_LAST_RX(O_LAST_RX)
    );

    assign outs = {O_TX_EN, O_WADDR, O_WDATA, O_RX_EN, O_RADDR, O_BUSY, O_DONE, O_PASS, O_ERR,
                   O_ERR_CNT, O_LAST_RX};

    always @(posedge clk) begin
        if (I_RST) begin
            rx_valid  = 1'b0;
            delay_cnt = 0;
            I_RDATA  <= 8'h00;
        end else begin
            I_RDATA <= 8'h00;
            if (O_TX_EN) begin
                wr_cnt++;
                if (O_WADDR == 3'd1) begin
                    tx_log.push_back(O_WDATA);
                    rx_byte  = O_WDATA ^ ((byte_idx < 4'd8 && corrupt_mask[byte_idx[2:0]])
                                          ? 8'h5A : 8'h00);
                    rx_valid = 1'b1;
                    byte_idx = byte_idx + 4'd1;
                end else if (O_WADDR == 3'd4) begin
                    ss_wr_cnt++;
                    if (O_WDATA == 8'h00) ss_zero_cnt++;
                    else byte_idx = 4'd0;
                end
            end
            if (O_RX_EN) begin
                if (O_RADDR == 3'd2) begin
                    if (delay_cnt < poll_delay) begin
                        delay_cnt++;
                    end else begin
                        delay_cnt = 0;
                        I_RDATA <= {1'b0, rx_valid, !rx_valid && !trdy_stuck, 5'b00000};
                    end
                end else if (O_RADDR == 3'd0) begin
                    I_RDATA <= rx_byte;
                    rx_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (O_TX_EN && O_RX_EN) begin
            proto_viol++;
            $display("FAIL proto_both_strobes t=%0t tx_en=%b rx_en=%b required one-hot", $time,
                     O_TX_EN, O_RX_EN);
        end
        if ((!O_TX_EN && (O_WADDR !== 3'd0 || O_WDATA !== 8'h00)) ||
            (!O_RX_EN && O_RADDR !== 3'd0)) begin
            proto_viol++;
            $display("FAIL proto_idle_bus t=%0t waddr=%h wdata=%h raddr=%h required 0", $time,
                     O_WADDR, O_WDATA, O_RADDR);
        end
        if ((O_TX_EN && prev_tx && O_WADDR == prev_waddr) || (O_RX_EN && prev_rx) ||
            (O_DONE && prev_done)) begin
            proto_viol++;
            $display("FAIL proto_pulse_width t=%0t tx=%b rx=%b done=%b required 1-cycle", $time,
                     O_TX_EN, O_RX_EN, O_DONE);
        end
        if (O_DONE) done_cnt++;
        prev_tx    = O_TX_EN;
        prev_rx    = O_RX_EN;
        prev_done  = O_DONE;
        prev_waddr = O_WADDR;
    end

    task automatic pulse_start(input logic [7:0] seed);
        @(negedge clk);
        I_START = 1'b1;
        I_SEED  = seed;
        @(negedge clk);
        I_START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit to);
        cyc = 0;
        while (O_DONE !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        to = (O_DONE !== 1'b1);
    endtask

    task automatic test_reset();
        I_RST   = 1'b1;
        I_START = 1'b0;
        I_SEED  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (outs !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h required=0", outs);
        end
        I_RST = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({O_BUSY, O_DONE} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle busy,done got=%b required=00", {O_BUSY, O_DONE});
        end
    endtask

    task automatic test_clean_burst(input string name, input logic [7:0] seed);
        int   base_tx, base_wr, base_ssz, base_done, cyc, bad;
        bit   to;
        logic [7:0] e;
        base_tx   = tx_log.size();
        base_wr   = wr_cnt;
        base_ssz  = ss_zero_cnt;
        base_done = done_cnt;
        pulse_start(seed);
        checks++;
        if (O_BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy got=%b required=1", name, O_BUSY);
        end
        wait_done(800, cyc, to);
        checks++;
        if (to !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_timeout waited=%0d cycles required DONE", name, cyc);
        end
        checks++;
        if ({O_PASS, O_ERR, O_ERR_CNT} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL %s_status pass=%b err=%b cnt=%0d required pass=1 err=0 cnt=0", name,
                     O_PASS, O_ERR, O_ERR_CNT);
        end
        e = seed + 8'(BL - 1);
        checks++;
        if (O_LAST_RX !== e) begin
            errors++;
            $display("FAIL %s_last_rx got=%h required=%h", name, O_LAST_RX, e);
        end
        bad = 0;
        for (int i = 0; i < int'(BL); i++) begin
            e = seed + 8'(i);
            if (base_tx + i >= tx_log.size() || tx_log[base_tx + i] !== e) bad++;
        end
        checks++;
        if (bad != 0 || tx_log.size() - base_tx != int'(BL)) begin
            errors++;
            $display("FAIL %s_tx_seq bad=%0d count=%0d required 0 bad and %0d bytes from %h",
                     name, bad, tx_log.size() - base_tx, BL, seed);
        end
        checks++;
        if (wr_cnt - base_wr != int'(BL) + 3 || ss_zero_cnt - base_ssz != 1) begin
            errors++;
            $display("FAIL %s_writes got=%0d ss0=%0d required=%0d ss0=1", name,
                     wr_cnt - base_wr, ss_zero_cnt - base_ssz, BL + 3);
        end
        @(negedge clk);
        checks++;
        if ({O_DONE, O_BUSY} !== 2'b00 || done_cnt - base_done != 1) begin
            errors++;
            $display("FAIL %s_done_pulse done,busy=%b pulses=%0d required 00 and 1", name,
                     {O_DONE, O_BUSY}, done_cnt - base_done);
        end
    endtask

    task automatic test_corrupt();
        int base_ssz, base_wr, cyc;
        bit to;
        corrupt_mask = 8'b0010_0100;
        poll_delay   = 2;
        base_ssz     = ss_zero_cnt;
        base_wr      = wr_cnt;
        pulse_start(8'h10);
        wait_done(800, cyc, to);
        checks++;
        if (to !== 1'b0 || ss_zero_cnt - base_ssz != 1) begin
            errors++;
            $display("FAIL corrupt_done to=%b ss0=%0d required DONE after one SSMASK=0", to,
                     ss_zero_cnt - base_ssz);
        end
        checks++;
        if ({O_PASS, O_ERR, O_ERR_CNT} !== {2'b01, 8'd2}) begin
            errors++;
            $display("FAIL corrupt_status pass=%b err=%b cnt=%0d required pass=0 err=1 cnt=2",
                     O_PASS, O_ERR, O_ERR_CNT);
        end
        checks++;
        if (O_LAST_RX !== 8'h17 || wr_cnt - base_wr != int'(BL) + 3) begin
            errors++;
            $display("FAIL corrupt_rx_wr last=%h wr=%0d required 17 and %0d", O_LAST_RX,
                     wr_cnt - base_wr, BL + 3);
        end
        corrupt_mask = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int base_tx, base_wr, base_ssz, base_done, cyc;
        bit to;
        trdy_stuck = 1'b1;
        poll_delay = 0;
        base_tx    = tx_log.size();
        base_wr    = wr_cnt;
        base_ssz   = ss_zero_cnt;
        base_done  = done_cnt;
        pulse_start(8'h33);
        wait_done(300, cyc, to);
        checks++;
        if (to !== 1'b0 || cyc < int'(TMO) || cyc > int'(TMO + RDL + 4)) begin
            errors++;
            $display("FAIL timeout_latency cycles=%0d required %0d..%0d", cyc, TMO,
                     TMO + RDL + 4);
        end
        checks++;
        if ({O_PASS, O_ERR, O_ERR_CNT} !== {2'b01, 8'd0}) begin
            errors++;
            $display("FAIL timeout_status pass=%b err=%b cnt=%0d required pass=0 err=1 cnt=0",
                     O_PASS, O_ERR, O_ERR_CNT);
        end
        checks++;
        if (tx_log.size() != base_tx || wr_cnt - base_wr != 3 || ss_zero_cnt - base_ssz != 1) begin
            errors++;
            $display("FAIL timeout_writes tx=%0d wr=%0d ss0=%0d required tx=0 wr=3 ss0=1",
                     tx_log.size() - base_tx, wr_cnt - base_wr, ss_zero_cnt - base_ssz);
        end
        @(negedge clk);
        checks++;
        if (done_cnt - base_done != 1 || O_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done pulses=%0d busy=%b required 1 and 0",
                     done_cnt - base_done, O_BUSY);
        end
        trdy_stuck = 1'b0;
    endtask

    task automatic test_restart_ignored();
        int base_tx, cyc, bad;
        bit to;
        logic [7:0] e;
        poll_delay = 1;
        base_tx    = tx_log.size();
        pulse_start(8'h20);
        repeat (12) @(negedge clk);
        pulse_start(8'h99);
        wait_done(800, cyc, to);
        bad = 0;
        for (int i = 0; i < int'(BL); i++) begin
            e = 8'h20 + 8'(i);
            if (base_tx + i >= tx_log.size() || tx_log[base_tx + i] !== e) bad++;
        end
        checks++;
        if (to !== 1'b0 || bad != 0 || O_PASS !== 1'b1) begin
            errors++;
            $display("FAIL restart_ignored to=%b bad=%0d pass=%b required 0,0,1", to, bad,
                     O_PASS);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tx_log.size() - base_tx != int'(BL) || O_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL restart_no_second bytes=%0d busy=%b required %0d and 0",
                     tx_log.size() - base_tx, O_BUSY, BL);
        end
    endtask

    task automatic test_reset_mid_burst();
        int base_tx, n, ssz;
        base_tx = tx_log.size();
        pulse_start(8'h30);
        n = 0;
        while (tx_log.size() - base_tx < 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_log.size() - base_tx < 3) begin
            errors++;
            $display("FAIL midrst_reach_byte3 bytes=%0d required>=3", tx_log.size() - base_tx);
        end
        ssz   = ss_zero_cnt;
        I_RST = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 36'd0) begin
            errors++;
            $display("FAIL midrst_outputs got=%h required=0", outs);
        end
        I_RST = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (ss_zero_cnt != ssz || O_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_cleanup ss0=%0d busy=%b required 0 and 0",
                     ss_zero_cnt - ssz, O_BUSY);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_viol !== 0) begin
            errors++;
            $display("FAIL protocol violations=%0d required=0", proto_viol);
        end
    endtask

    initial begin
        test_reset();
        test_clean_burst("loopback", 8'h10);
        test_corrupt();
        poll_delay = 1;
        test_clean_burst("wrap", 8'hFE);
        test_timeout();
        test_restart_ignored();
        test_reset_mid_burst();
        poll_delay = 0;
        test_clean_burst("after_rst", 8'h40);
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
